// File: rtl/ms_reaction_timer_if.sv
// Control and status bundle between the reaction-game FSM and the millisecond timer.
// The FSM side is the master (drives direction/enable/load); the timer is the slave.
interface ms_reaction_timer_if;
    logic        up;
    logic        enable;
    logic        load;
    logic [10:0] load_value;
    logic [10:0] timer_value;
    logic        ms_tick;
    logic        at_zero;
    logic        at_max;
    logic        expired;

    modport master (
        output up, enable, load, load_value,
        input  timer_value, ms_tick, at_zero, at_max, expired
    );

    modport slave (
        input  up, enable, load, load_value,
        output timer_value, ms_tick, at_zero, at_max, expired
    );
endinterface

// File: rtl/ms_reaction_timer.sv
// Millisecond prescaler plus saturating 11-bit up/down counter; tick and new value appear one cycle after the wrap edge.
// No backpressure: enable=0 freezes prescaler and count (pause), load overrides everything except reset.
module ms_reaction_timer #(
    parameter int MAX_MS      = 2047,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic              clk,
    input  logic              reset,
    ms_reaction_timer_if.slave tif
);
    localparam int              PW      = $clog2(CLKS_PER_MS);
    localparam logic [PW-1:0]   PS_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [10:0]     MAX_V   = 11'(MAX_MS);

    logic [PW-1:0] prescale_q, prescale_d;
    logic [10:0]   timer_q, timer_d;
    logic          ms_tick_q, ms_tick_d;
    logic          expired_q, expired_d;
    logic          wrap;

    assign wrap = tif.enable && (prescale_q == PS_LAST);

    always_comb begin
        prescale_d = prescale_q;
        timer_d    = timer_q;
        ms_tick_d  = 1'b0;
        expired_d  = 1'b0;

        if (tif.load) begin
            // Restart the millisecond so the first step after a load is a full period away.
            prescale_d = '0;
            timer_d    = (tif.load_value > MAX_V) ? MAX_V : tif.load_value;
        end else if (wrap) begin
            prescale_d = '0;
            ms_tick_d  = 1'b1;
            if (tif.up) begin
                if (timer_q < MAX_V) timer_d = timer_q + 11'd1;
            end else begin
                if (timer_q != 11'd0) timer_d = timer_q - 11'd1;
                expired_d = (timer_q == 11'd1);
            end
        end else if (tif.enable) begin
            prescale_d = prescale_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            timer_q    <= '0;
            ms_tick_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            timer_q    <= timer_d;
            ms_tick_q  <= ms_tick_d;
            expired_q  <= expired_d;
        end
    end

    assign tif.timer_value = timer_q;
    assign tif.ms_tick     = ms_tick_q;
    assign tif.expired     = expired_q;
    assign tif.at_zero     = (timer_q == 11'd0);
    assign tif.at_max      = (timer_q == MAX_V);
endmodule

// File: tb/tb_ms_reaction_timer.sv
// Directed, table-driven check of the millisecond reaction timer with a 4-cycle millisecond.
module tb_ms_reaction_timer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ms_reaction_timer_if tif ();
    ms_reaction_timer_if tif2 ();

    ms_reaction_timer #(.MAX_MS(2047), .CLKS_PER_MS(4)) dut (
        .clk  (clk),
        .reset(reset),
        .tif  (tif.slave)
    );

    ms_reaction_timer #(.MAX_MS(1000), .CLKS_PER_MS(4)) dut_max1000 (
        .clk  (clk),
        .reset(reset),
        .tif  (tif2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        up;
        logic        en;
        logic        ld;
        logic [10:0] lv;
        int          n;
        logic [10:0] e_val;
        logic        e_tick;
        logic        e_zero;
        logic        e_max;
        logic        e_exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic up, input logic en, input logic ld, input int lv, input int n,
                           input int e_val, input logic e_tick, input logic e_zero,
                           input logic e_max, input logic e_exp);
        vec_t v;
        v.up = up; v.en = en; v.ld = ld; v.lv = 11'(lv); v.n = n;
        v.e_val = 11'(e_val); v.e_tick = e_tick; v.e_zero = e_zero; v.e_max = e_max; v.e_exp = e_exp;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] a_val, input logic a_tick,
                         input logic a_zero, input logic a_max, input logic a_exp,
                         input logic [10:0] e_val, input logic e_tick, input logic e_zero,
                         input logic e_max, input logic e_exp);
        n_checks++;
        if ({a_val, a_tick, a_zero, a_max, a_exp} !== {e_val, e_tick, e_zero, e_max, e_exp}) begin
            n_fail++;
            $display("FAIL %s: got value=%0d tick=%b zero=%b max=%b expired=%b, want value=%0d tick=%b zero=%b max=%b expired=%b",
                     name, a_val, a_tick, a_zero, a_max, a_exp, e_val, e_tick, e_zero, e_max, e_exp);
        end
    endtask

    task automatic chk1(input string name, input logic [10:0] e_val, input logic e_tick,
                        input logic e_zero, input logic e_max, input logic e_exp);
        check(name, tif.timer_value, tif.ms_tick, tif.at_zero, tif.at_max, tif.expired,
              e_val, e_tick, e_zero, e_max, e_exp);
    endtask

    task automatic chk2(input string name, input logic [10:0] e_val, input logic e_tick,
                        input logic e_zero, input logic e_max, input logic e_exp);
        check(name, tif2.timer_value, tif2.ms_tick, tif2.at_zero, tif2.at_max, tif2.expired,
              e_val, e_tick, e_zero, e_max, e_exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        tif.up = 1'b0; tif.enable = 1'b0; tif.load = 1'b0; tif.load_value = '0;
        tif2.up = 1'b0; tif2.enable = 1'b0; tif2.load = 1'b0; tif2.load_value = '0;

        #3;
        chk1("reset_state", 11'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk2("reset_state_m1000", 11'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-count: 10 enabled cycles leave value 2, then reset between edges.
        step(1);
        reset = 1'b0;
        tif.enable = 1'b1; tif.up = 1'b1;
        step(10);
        chk1("pre_reset_count", 11'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk1("async_reset", 11'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tif.enable = 1'b0;
        step(1);
        reset = 1'b0;

        //       up   en   ld   lv    n   val  tick zero max  exp
        add_vec(1'b1,1'b1,1'b0,   0,  4,    1,1'b1,1'b0,1'b0,1'b0); // 0 first tick
        add_vec(1'b1,1'b1,1'b0,   0,  1,    1,1'b0,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  3,    2,1'b1,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  4,    3,1'b1,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b1,   3,  1,    3,1'b0,1'b0,1'b0,1'b0); // 4 load countdown
        add_vec(1'b0,1'b1,1'b0,   0,  4,    2,1'b1,1'b0,1'b0,1'b0);
        add_vec(1'b0,1'b1,1'b0,   0,  4,    1,1'b1,1'b0,1'b0,1'b0);
        add_vec(1'b0,1'b1,1'b0,   0,  3,    1,1'b0,1'b0,1'b0,1'b0);
        add_vec(1'b0,1'b1,1'b0,   0,  1,    0,1'b1,1'b1,1'b0,1'b1); // 8 expiry
        add_vec(1'b0,1'b1,1'b0,   0,  1,    0,1'b0,1'b1,1'b0,1'b0);
        add_vec(1'b0,1'b1,1'b0,   0,  3,    0,1'b1,1'b1,1'b0,1'b0); // 10 hold at 0
        add_vec(1'b1,1'b1,1'b1,2046,  1, 2046,1'b0,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  4, 2047,1'b1,1'b0,1'b1,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  4, 2047,1'b1,1'b0,1'b1,1'b0); // 13 saturate
        add_vec(1'b1,1'b1,1'b1,2047,  1, 2047,1'b0,1'b0,1'b1,1'b0);
        add_vec(1'b1,1'b1,1'b1,   0,  1,    0,1'b0,1'b1,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  2,    0,1'b0,1'b1,1'b0,1'b0); // 16 pause setup
        add_vec(1'b1,1'b0,1'b0,   0, 20,    0,1'b0,1'b1,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  1,    0,1'b0,1'b1,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  1,    1,1'b1,1'b0,1'b0,1'b0); // 19 resumed tick
        add_vec(1'b1,1'b1,1'b0,   0,  3,    1,1'b0,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b1,  10,  1,   10,1'b0,1'b0,1'b0,1'b0); // 21 load beats wrap
        add_vec(1'b1,1'b1,1'b0,   0,  3,   10,1'b0,1'b0,1'b0,1'b0);
        add_vec(1'b1,1'b1,1'b0,   0,  1,   11,1'b1,1'b0,1'b0,1'b0);
        add_vec(1'b0,1'b1,1'b0,   0,  2,   11,1'b0,1'b0,1'b0,1'b0); // 24 direction flip mid-ms
        add_vec(1'b1,1'b1,1'b0,   0,  2,   12,1'b1,1'b0,1'b0,1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            tif.up = vecs[i].up; tif.enable = vecs[i].en;
            tif.load = vecs[i].ld; tif.load_value = vecs[i].lv;
            step(vecs[i].n);
            chk1($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_tick, vecs[i].e_zero,
                 vecs[i].e_max, vecs[i].e_exp);
        end
        tif.enable = 1'b0;

        // Clamp and saturation with a reduced ceiling.
        tif2.load = 1'b1; tif2.load_value = 11'd1500; tif2.enable = 1'b1; tif2.up = 1'b1;
        step(1);
        chk2("clamp_1500", 11'd1000, 1'b0, 1'b0, 1'b1, 1'b0);
        tif2.load = 1'b0;
        step(4);
        chk2("sat_1000", 11'd1000, 1'b1, 1'b0, 1'b1, 1'b0);
        tif2.load = 1'b1; tif2.load_value = 11'd999;
        step(1);
        chk2("load_999", 11'd999, 1'b0, 1'b0, 1'b0, 1'b0);
        tif2.load = 1'b0;
        step(4);
        chk2("reach_1000", 11'd1000, 1'b1, 1'b0, 1'b1, 1'b0);
        tif2.up = 1'b0;
        step(4);
        chk2("down_from_1000", 11'd999, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ms_reaction_timer.md
Name: ms_reaction_timer

Overview:
Millisecond timebase and 11-bit up/down counter that produces timer_value for the reaction-time FSM. The FSM drives up and enable.
- Counting down serves as the randomised pre-light delay.
- Counting up measures the player's reaction.
Divides the 50 MHz board clock down to 1 ms ticks. Saturates at 0 and MAX_MS, and flags expiry of a countdown.

Parameters:
MAX_MS, 2047, saturation ceiling of timer_value in ms; must fit in 11 bits.
CLKS_PER_MS, 50000, clk cycles per millisecond tick; must be >= 2; the bench overrides it to 4.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high; clears all state.
up  input  1  count direction: 1 = increment, 0 = decrement; sampled only on a tick.
enable  input  1  1 = prescaler runs; 0 = prescaler and count frozen (pause).
load  input  1  synchronous load strobe; priority over enable.
load_value  input  11  value loaded on load; clamped to MAX_MS.
timer_value  output  11  current count in ms.
ms_tick  output  1  one-cycle pulse on each prescaler wrap while enabled.
at_zero  output  1  timer_value == 0.
at_max  output  1  timer_value == MAX_MS.
expired  output  1  one-cycle pulse when a down-count steps 1 -> 0.

Behaviour:
Reset (async, any time, including mid-millisecond):
- prescale_cnt=0, timer_value=0, ms_tick=0, expired=0.
- Consequently at_zero=1 and at_max=0.
- First tick occurs CLKS_PER_MS enabled cycles after reset deasserts.

Registers:
- prescale_cnt, width $clog2(CLKS_PER_MS).
- timer_value, 11 bits.
- ms_tick and expired, both registered.

Per rising clk edge, in priority order:
1. load=1:
   - timer_value <= min(load_value, MAX_MS).
   - prescale_cnt <= 0.
   - ms_tick <= 0, expired <= 0.
   - enable and up are ignored this cycle.
2. enable=1 and prescale_cnt == CLKS_PER_MS-1:
   - prescale_cnt <= 0, ms_tick <= 1.
   - up=1: timer_value <= timer_value+1 if < MAX_MS, else hold (saturate).
   - up=0: timer_value <= timer_value-1 if > 0, else hold.
   - expired <= 1 only when up=0 and timer_value == 1.
3. enable=1 otherwise:
   - prescale_cnt <= prescale_cnt+1.
   - ms_tick <= 0, expired <= 0.
4. enable=0:
   - prescale_cnt and timer_value hold.
   - ms_tick <= 0, expired <= 0.
   - Re-enabling resumes the partial millisecond; it does not restart it.

Timing and flags:
- ms_tick and the new timer_value appear in the same cycle (the cycle after the wrap edge).
- at_zero and at_max are combinational compares of the timer_value register; no extra latency.
- At MAX_MS with up=1, ms_tick still pulses and the value holds; no wrap-around.
- At 0 with up=0, ms_tick still pulses, the value holds and expired stays 0.
- expired fires exactly once per countdown.

Direction and pause:
- up may change at any cycle. Only its value on the tick edge matters; the prescaler is not reset by a direction change.

Simultaneous events:
- load with a wrap pending: load wins; no tick, no step, no expired.
- reset overrides everything asynchronously.

Arithmetic:
- All unsigned, 11-bit; no signed intermediates.
- The load clamp compares full 11-bit values.

Test Plan:
1. Reset mid-count: with CLKS_PER_MS=4, enable=1, up=1, run 10 cycles (timer_value=2). Assert reset between clk edges -> timer_value=0, at_zero=1 and ms_tick=0 immediately, without waiting for a clk edge.
2. Up count and tick spacing: reset released, enable=1, up=1 -> ms_tick pulses every 4th cycle; timer_value reads 1,2,3 after 4,8,12 cycles.
3. Countdown expiry: load with load_value=3, then enable=1, up=0 -> values 2,1,0 at cycles 4,8,12.
   - expired=1 only in the cycle timer_value becomes 0.
   - 4 more cycles -> value stays 0, ms_tick pulses, expired=0.
4. Saturation and clamp:
   - load with load_value=2046, up=1 -> 2047 after one tick, at_max=1; further ticks hold 2047.
   - load with load_value=2047 -> 2047.
   - With MAX_MS=1000, load_value=1500 -> 1000.
5. Pause/resume: enable=1 for 2 cycles, enable=0 for 20 cycles, enable=1 -> first tick after 2 more enabled cycles; value unchanged during the pause.
6. Load vs pending wrap: load asserted on the cycle prescale_cnt=3 with load_value=10 -> timer_value=10, ms_tick=0, next tick 4 cycles later.
